// File: rtl/gate_vector_checker_if.sv
// Stimulus/response bundle between gate_vector_checker and the two-input gate block.
// Combinational wiring only; no flow control, the checker owns vector timing.
interface gate_vector_checker_if;
    logic       start;
    logic       and_g;
    logic       or_g;
    logic       not_g;
    logic       buf_g;
    logic       nand_g;
    logic       nor_g;
    logic       xor_g;
    logic       xnor_g;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] err_mask;

    modport master (
        input  start,
        input  and_g, or_g, not_g, buf_g, nand_g, nor_g, xor_g, xnor_g,
        output a, b, busy, done, pass, err_count, err_mask
    );

    modport slave (
        output start,
        output and_g, or_g, not_g, buf_g, nand_g, nor_g, xor_g, xnor_g,
        input  a, b, busy, done, pass, err_count, err_mask
    );
endinterface

// File: rtl/gate_vector_checker.sv
// Sequences 00/01/10/11 into the gate block, samples its 8 outputs on the last hold cycle.
// Run lasts 4*HOLD_CYCLES*REPEAT cycles after start; start is ignored while busy.
module gate_vector_checker #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned REPEAT      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_vector_checker_if.master  gif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] hc_q, hc_d;
    logic [3:0] rep_q, rep_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [7:0] err_count_q, err_count_d;
    logic [7:0] err_mask_q, err_mask_d;

    logic [7:0] exp_out;
    logic [7:0] got_out;
    logic [7:0] mism;
    logic [1:0] vec_nx;
    logic       last_hold;
    logic       last_vec;

    always_comb begin
        // Bit order: [0] and .. [7] xnor
        exp_out   = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q),
                     a_q, ~a_q, a_q | b_q, a_q & b_q};
        got_out   = {gif.xnor_g, gif.xor_g, gif.nor_g, gif.nand_g,
                     gif.buf_g, gif.not_g, gif.or_g, gif.and_g};
        mism      = got_out ^ exp_out;
        vec_nx    = vec_q + 2'd1;
        last_hold = (hc_q == 8'(HOLD_CYCLES - 1));
        last_vec  = (vec_q == 2'd3) && (rep_q == 4'(REPEAT - 1));

        state_d     = state_q;
        vec_d       = vec_q;
        hc_d        = hc_q;
        rep_d       = rep_q;
        a_d         = a_q;
        b_d         = b_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;

        case (state_q)
            ST_RUN: begin
                hc_d = hc_q + 8'd1;
                if (last_hold) begin
                    if (mism != 8'd0) begin
                        err_mask_d = err_mask_q | mism;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                    if (last_vec) begin
                        state_d = ST_DONE;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        hc_d  = 8'd0;
                        vec_d = vec_nx;
                        a_d   = vec_nx[1];
                        b_d   = vec_nx[0];
                        if (vec_q == 2'd3) begin
                            rep_d = rep_q + 4'd1;
                        end
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept a start and clear results on that edge
                if (gif.start) begin
                    state_d     = ST_RUN;
                    vec_d       = 2'd0;
                    hc_d        = 8'd0;
                    rep_d       = 4'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    err_count_d = 8'd0;
                    err_mask_d  = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= 2'd0;
            hc_q        <= 8'd0;
            rep_q       <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            err_count_q <= 8'd0;
            err_mask_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            hc_q        <= hc_d;
            rep_q       <= rep_d;
            a_q         <= a_d;
            b_q         <= b_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
        end
    end

    assign gif.a         = a_q;
    assign gif.b         = b_q;
    assign gif.busy      = (state_q == ST_RUN);
    assign gif.done      = (state_q == ST_DONE);
    assign gif.pass      = (state_q == ST_DONE) && (err_count_q == 8'd0);
    assign gif.err_count = err_count_q;
    assign gif.err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Two checker instances (10x1 and 3x2) against a faultable gate model and a
// run-timeline reference model; directed scenarios followed by random traffic.
module tb_gate_vector_checker;

    localparam int HOLD0 = 10;
    localparam int REP0  = 1;
    localparam int HOLD1 = 3;
    localparam int REP1  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [2];
    logic [7:0] f_en  [2];
    logic [7:0] f_val [2];

    gate_vector_checker_if ifc0 ();
    gate_vector_checker_if ifc1 ();

    gate_vector_checker #(.HOLD_CYCLES(HOLD0), .REPEAT(REP0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_v[0]),
        .gif   (ifc0.master)
    );

    gate_vector_checker #(.HOLD_CYCLES(HOLD1), .REPEAT(REP1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_v[1]),
        .gif   (ifc1.master)
    );

    // Truth table per vector {a,b}; bit order [0] and .. [7] xnor
    function automatic logic [7:0] truth(input int v);
        case (v)
            0:       return 8'hB4;
            1:       return 8'h56;
            2:       return 8'h5A;
            default: return 8'h8B;
        endcase
    endfunction

    function automatic logic [7:0] gate_block(input logic a, input logic b, input logic [7:0] en,
                                              input logic [7:0] val);
        logic [7:0] ideal;
        ideal = truth({30'd0, a, b});
        return (ideal & ~en) | (val & en);
    endfunction

    assign {ifc0.xnor_g, ifc0.xor_g, ifc0.nor_g, ifc0.nand_g,
            ifc0.buf_g, ifc0.not_g, ifc0.or_g, ifc0.and_g} = gate_block(ifc0.a, ifc0.b, f_en[0], f_val[0]);
    assign {ifc1.xnor_g, ifc1.xor_g, ifc1.nor_g, ifc1.nand_g,
            ifc1.buf_g, ifc1.not_g, ifc1.or_g, ifc1.and_g} = gate_block(ifc1.a, ifc1.b, f_en[1], f_val[1]);

    logic [20:0] obs [2];
    assign obs[0] = {ifc0.a, ifc0.b, ifc0.busy, ifc0.done, ifc0.pass, ifc0.err_count, ifc0.err_mask};
    assign obs[1] = {ifc1.a, ifc1.b, ifc1.busy, ifc1.done, ifc1.pass, ifc1.err_count, ifc1.err_mask};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: a run is just its start edge plus the faults in place then
    bit         m_started [2];
    int         m_t0      [2];
    logic [7:0] m_en      [2];
    logic [7:0] m_val     [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int hold_of(input int i);
        return (i == 0) ? HOLD0 : HOLD1;
    endfunction

    function automatic int total_of(input int i);
        return (i == 0) ? 4 * HOLD0 * REP0 : 4 * HOLD1 * REP1;
    endfunction

    function automatic bit mdl_busy(input int i);
        return m_started[i] && ((cyc - m_t0[i]) < total_of(i));
    endfunction

    function automatic logic [20:0] exp_out(input int i);
        int         m, ns, v, cnt;
        logic       ea, eb, ebusy, edone;
        logic [7:0] mask, mm;
        if (!m_started[i]) return 21'd0;
        m = cyc - m_t0[i];
        if (m < total_of(i)) begin
            v     = (m / hold_of(i)) % 4;
            ea    = v[1];
            eb    = v[0];
            ebusy = 1'b1;
            edone = 1'b0;
            ns    = m / hold_of(i);
        end else begin
            ea    = 1'b0;
            eb    = 1'b0;
            ebusy = 1'b0;
            edone = 1'b1;
            ns    = total_of(i) / hold_of(i);
        end
        cnt  = 0;
        mask = 8'd0;
        for (int j = 0; j < ns; j++) begin
            mm = m_en[i] & (m_val[i] ^ truth(j % 4));
            if (mm != 8'd0) cnt++;
            mask |= mm;
        end
        if (cnt > 255) cnt = 255;
        return {ea, eb, ebusy, edone, edone && (cnt == 0), cnt[7:0], mask};
    endfunction

    // Inputs are set by the caller after a falling edge; one call = one rising edge
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_v[i]) begin
                m_started[i] = 1'b0;
            end else if (((i == 0) ? ifc0.start : ifc1.start) && !mdl_busy(i)) begin
                m_started[i] = 1'b1;
                m_t0[i]      = cyc + 1;
                m_en[i]      = f_en[i];
                m_val[i]     = f_val[i];
            end
        end
        cyc++;
        @(negedge clk);
        check_eq($sformatf("cyc%0d_u0", cyc), {11'd0, obs[0]}, {11'd0, exp_out(0)});
        check_eq($sformatf("cyc%0d_u1", cyc), {11'd0, obs[1]}, {11'd0, exp_out(1)});
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i]     = 1'b0;
            f_en[i]      = 8'd0;
            f_val[i]     = 8'd0;
            m_started[i] = 1'b0;
            m_t0[i]      = 0;
            m_en[i]      = 8'd0;
            m_val[i]     = 8'd0;
        end
        ifc0.start = 1'b1;
        ifc1.start = 1'b1;
        @(negedge clk);

        // Reset held with start asserted
        repeat (3) step();
        check_eq("reset_u0", {11'd0, obs[0]}, 32'd0);
        check_eq("reset_u1", {11'd0, obs[1]}, 32'd0);
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        ifc0.start = 1'b0;
        ifc1.start = 1'b0;
        step();
        check_eq("idle_no_run", {31'd0, ifc0.busy}, 32'd0);

        // Clean pass on u0; and/not stuck at 1 with repeat on u1
        f_en[1]  = 8'h05;
        f_val[1] = 8'h05;
        ifc0.start = 1'b1;
        ifc1.start = 1'b1;
        step();
        check_eq("start_busy", {30'd0, ifc0.busy, ifc0.a}, 32'h2);
        ifc0.start = 1'b0;
        ifc1.start = 1'b0;
        repeat (39) step();
        check_eq("clean_not_done_t39", {31'd0, ifc0.done}, 32'd0);
        step();
        check_eq("clean_pass", {30'd0, ifc0.done, ifc0.pass}, 32'h3);
        check_eq("clean_cnt", {24'd0, ifc0.err_count}, 32'd0);
        check_eq("clean_mask", {24'd0, ifc0.err_mask}, 32'd0);
        check_eq("multi_cnt", {24'd0, ifc1.err_count}, 32'd8);
        check_eq("multi_mask", {24'd0, ifc1.err_mask}, 32'h05);
        check_eq("multi_pass", {30'd0, ifc1.done, ifc1.pass}, 32'h2);

        // xor stuck at 0
        f_en[0]  = 8'h40;
        f_val[0] = 8'h00;
        ifc0.start = 1'b1;
        step();
        ifc0.start = 1'b0;
        repeat (40) step();
        check_eq("xor_cnt", {24'd0, ifc0.err_count}, 32'd2);
        check_eq("xor_mask", {24'd0, ifc0.err_mask}, 32'h40);
        check_eq("xor_pass", {31'd0, ifc0.pass}, 32'd0);

        // Restart from DONE with an ideal block
        f_en[0] = 8'h00;
        ifc0.start = 1'b1;
        step();
        ifc0.start = 1'b0;
        check_eq("restart_clear", {14'd0, ifc0.done, ifc0.err_count, ifc0.err_mask}, 32'd0);
        repeat (40) step();
        check_eq("restart_pass", {31'd0, ifc0.pass}, 32'd1);

        // Start while busy is ignored, then a mid-run reset
        ifc0.start = 1'b1;
        step();
        ifc0.start = 1'b0;
        repeat (4) step();
        ifc0.start = 1'b1;
        step();
        ifc0.start = 1'b0;
        repeat (9) step();
        check_eq("busy_start_vec", {30'd0, ifc0.a, ifc0.b}, 32'h1);
        rst_v[0] = 1'b0;
        step();
        check_eq("mid_reset", {11'd0, obs[0]}, 32'd0);
        rst_v[0] = 1'b1;
        step();
        ifc0.start = 1'b1;
        step();
        ifc0.start = 1'b0;
        repeat (40) step();
        check_eq("post_reset_pass", {31'd0, ifc0.pass}, 32'd1);

        // Random faults, start pulses (some while busy) and occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                logic st;
                st = 1'b0;
                if (!mdl_busy(i)) begin
                    if ($urandom_range(0, 7) == 0) begin
                        f_en[i]  = 8'($urandom);
                        f_val[i] = 8'($urandom);
                        st       = 1'b1;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    st = 1'b1;
                end
                rst_v[i] = ($urandom_range(0, 299) != 0);
                if (i == 0) ifc0.start = st;
                else        ifc1.start = st;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
